// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: FSM state enum and encodings, ctrl-field bit indices, register-zero,
// and the packed per-cycle pipeline control word with its fixed decodes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_e;

    // Plain-vector copies of the state encodings for the registered FSM.
    localparam logic [1:0] ST_RUN      = RUN;
    localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;
    localparam logic [1:0] ST_HALT     = HALT;

    localparam int CTRL_REG_W = 2;
    localparam int CTRL_MEM_W = 1;
    localparam int CTRL_MEM_R = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int WAIT_W = 8;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_bubble;
    } pipe_ctl_t;

    // Everything held, bubble into WB, front-end contents kept.
    localparam pipe_ctl_t CTL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                         id_ex_en: 1'b0, id_ex_flush: 1'b0,
                                         ex_mem_en: 1'b0, mem_wb_bubble: 1'b1};

    // Reset: nothing loads, every stage register is forced to a NOP.
    localparam pipe_ctl_t CTL_RESET  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                         id_ex_en: 1'b0, id_ex_flush: 1'b1,
                                         ex_mem_en: 1'b0, mem_wb_bubble: 1'b1};

    // Free-running decode once no memory stall is pending.
    // Branch wins over load-use because the ID instruction is squashed anyway.
    function automatic pipe_ctl_t run_decode(input logic branch_taken, input logic load_use);
        pipe_ctl_t c;
        c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
              id_ex_en: 1'b1, id_ex_flush: 1'b0,
              ex_mem_en: 1'b1, mem_wb_bubble: 1'b0};
        if (branch_taken) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_en       = 1'b0;
            c.if_id_en    = 1'b0;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline datapath.
// Latency: wires only.
// Backpressure: n/a; stalls are expressed through the enable/flush signals themselves.
// master = hazard controller (hazard info in, stage controls out); slave = datapath.
// With HAZ_PERF_CNT_EN defined the bundle also carries stall_cycles, flush_count, loaduse_count.
interface pipe_hazard_ctrl_if;

    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [2:0]  ex_ctrl;
    logic [4:0]  ex_rd_addr;
    logic [2:0]  mem_ctrl;
    logic        ex_branch_taken;
    logic        dmem_ready;

    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_en;
    logic        id_ex_flush;
    logic        ex_mem_en;
    logic        mem_wb_bubble;
    logic        mem_timeout;
    logic [1:0]  state;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic [15:0] loaduse_count;
`endif

    modport master (
        input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
        input  ex_ctrl, ex_rd_addr, mem_ctrl, ex_branch_taken, dmem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        output ex_mem_en, mem_wb_bubble, mem_timeout, state
`ifdef HAZ_PERF_CNT_EN
        , output stall_cycles, flush_count, loaduse_count
`endif
    );

    modport slave (
        output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
        output ex_ctrl, ex_rd_addr, mem_ctrl, ex_branch_taken, dmem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        input  ex_mem_en, mem_wb_bubble, mem_timeout, state
`ifdef HAZ_PERF_CNT_EN
        , input stall_cycles, flush_count, loaduse_count
`endif
    );

endinterface

// File: rtl/pipe_hazard_ctrl_wait_timer.sv
// Counts consecutive data-memory not-ready cycles for the hazard controller.
// Latency: count updates on the next rising edge; expired is combinational from the count.
// Backpressure: none; clr has priority over inc.
// Ports: clk, rst (async active-high), clr, inc, expired (count == MAX_WAIT-1).
module pipe_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expired = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use, taken branch, dmem wait, timeout HALT.
// Latency: controls are a combinational decode of state + inputs; state changes at the next edge.
// Backpressure: dmem not-ready freezes PC..EX/MEM and bubbles MEM/WB; MAX_WAIT misses -> sticky HALT.
// Ports: clk, rst (async active-high), bus (pipe_hazard_ctrl_if.master).
// Optional HAZ_PERF_CNT_EN adds saturating stall_cycles / flush_count / loaduse_count on bus.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.master  bus
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    pipe_ctl_t  ctl;
    logic       memreq;
    logic       mem_stall;
    logic       mem_done;
    logic       load_use;
    logic       lu_act;
    logic       timer_clr;
    logic       timer_inc;
    logic       timer_expired;

    assign memreq    = bus.mem_ctrl[CTRL_MEM_W] | bus.mem_ctrl[CTRL_MEM_R];
    assign mem_stall = memreq & ~bus.dmem_ready;
    // A request vanishing while frozen is treated as completion so we can never hang on it.
    assign mem_done  = bus.dmem_ready | ~memreq;

    assign load_use = bus.ex_ctrl[CTRL_MEM_R] & (bus.ex_rd_addr != REG_ZERO) &
                      ((bus.id_uses_rs & (bus.id_rs_addr == bus.ex_rd_addr)) |
                       (bus.id_uses_rt & (bus.id_rt_addr == bus.ex_rd_addr)));

    pipe_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        ctl       = CTL_FREEZE;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        lu_act    = 1'b0;
        if (rst) begin
            state_d = ST_RUN;
            ctl     = CTL_RESET;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        // Counter is 0 in RUN, so this lands it at 1: the first miss counts.
                        state_d   = ST_MEM_WAIT;
                        timer_inc = 1'b1;
                    end else begin
                        ctl    = run_decode(bus.ex_branch_taken, load_use);
                        lu_act = load_use & ~bus.ex_branch_taken;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_done) begin
                        if (timer_expired) begin
                            state_d = ST_HALT;
                        end else begin
                            timer_inc = 1'b1;
                        end
                    end else begin
                        // Release cycle: the branch/load-use held in EX/ID acts right now.
                        ctl       = run_decode(bus.ex_branch_taken, load_use);
                        lu_act    = load_use & ~bus.ex_branch_taken;
                        state_d   = ST_RUN;
                        timer_clr = 1'b1;
                    end
                end
                default: begin
                    // HALT, and the unused encoding 3 behaves the same.
                    state_d = ST_HALT;
                    ctl     = CTL_FREEZE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.pc_en         = ctl.pc_en;
    assign bus.if_id_en      = ctl.if_id_en;
    assign bus.if_id_flush   = ctl.if_id_flush;
    assign bus.id_ex_en      = ctl.id_ex_en;
    assign bus.id_ex_flush   = ctl.id_ex_flush;
    assign bus.ex_mem_en     = ctl.ex_mem_en;
    assign bus.mem_wb_bubble = ctl.mem_wb_bubble;
    assign bus.mem_timeout   = ~rst & ((state_q == ST_HALT) | (state_q == 2'd3));
    assign bus.state         = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;
    logic [15:0] loaduse_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
            loaduse_count_q <= '0;
        end else begin
            if (!ctl.pc_en && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (ctl.if_id_flush && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
            if (lu_act && (loaduse_count_q != '1)) begin
                loaduse_count_q <= loaduse_count_q + 1'b1;
            end
        end
    end

    assign bus.stall_cycles  = stall_cycles_q;
    assign bus.flush_count   = flush_count_q;
    assign bus.loaduse_count = loaduse_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (built with MAX_WAIT=4).
// Latency: outputs checked combinationally mid-cycle, state after each rising edge.
// Backpressure: dmem_ready driven directly to exercise wait, release and timeout.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .MAX_WAIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //                   ex_mem_en, mem_wb_bubble, mem_timeout, state[1:0]}
    localparam logic [9:0] V_RESET   = 10'b0010101000;
    localparam logic [9:0] V_RUN     = 10'b1101010000;
    localparam logic [9:0] V_LU      = 10'b0001110000;
    localparam logic [9:0] V_BR      = 10'b1111110000;
    localparam logic [9:0] V_FRZ_RUN = 10'b0000001000;
    localparam logic [9:0] V_FRZ_MW  = 10'b0000001001;
    localparam logic [9:0] V_REL_MW  = 10'b1101010001;
    localparam logic [9:0] V_BR_MW   = 10'b1111110001;
    localparam logic [9:0] V_HALT    = 10'b0000001110;

    function automatic logic [9:0] obs();
        return {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
                bus.ex_mem_en, bus.mem_wb_bubble, bus.mem_timeout, bus.state};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [2:0] exc, input logic [4:0] exrd,
                         input logic [2:0] memc, input logic br, input logic rdy);
        bus.id_rs_addr      = rs;
        bus.id_rt_addr      = rt;
        bus.id_uses_rs      = urs;
        bus.id_uses_rt      = urt;
        bus.ex_ctrl         = exc;
        bus.ex_rd_addr      = exrd;
        bus.mem_ctrl        = memc;
        bus.ex_branch_taken = br;
        bus.dmem_ready      = rdy;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle();
        rst = 1'b1;
        #1;
        check("reset_async", 32'(obs()), 32'(V_RESET));
        tick();
        check("reset_held", 32'(obs()), 32'(V_RESET));
        rst = 1'b0;
        #1;
        check("run_idle", 32'(obs()), 32'(V_RUN));

        // Load-use on rs: one stall cycle, then the bubble is in EX.
        tick();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 3'b101, 5'd5, 3'b000, 1'b0, 1'b0);
        check("load_use_rs", 32'(obs()), 32'(V_LU));
        tick();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0);
        check("load_use_after", 32'(obs()), 32'(V_RUN));

        // Destination r0 never creates a hazard.
        tick();
        drive(5'd0, 5'd0, 1'b1, 1'b0, 3'b101, 5'd0, 3'b000, 1'b0, 1'b0);
        check("zero_reg", 32'(obs()), 32'(V_RUN));

        // Taken branch overrides a simultaneous load-use.
        tick();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 3'b101, 5'd5, 3'b000, 1'b1, 1'b0);
        check("branch_over_lu", 32'(obs()), 32'(V_BR));
        tick();
        idle();
        check("branch_after", 32'(obs()), 32'(V_RUN));

        // Three not-ready cycles, then release.
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd0, 3'b001, 1'b0, 1'b0);
        check("memwait_c1", 32'(obs()), 32'(V_FRZ_RUN));
        tick();
        check("memwait_c2", 32'(obs()), 32'(V_FRZ_MW));
        tick();
        check("memwait_c3", 32'(obs()), 32'(V_FRZ_MW));
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd0, 3'b001, 1'b0, 1'b1);
        check("memwait_release", 32'(obs()), 32'(V_REL_MW));
        tick();
        idle();
        check("memwait_back_run", 32'(obs()), 32'(V_RUN));

`ifdef HAZ_PERF_CNT_EN
        check("perf_stall_cycles", bus.stall_cycles, 32'd4);
        check("perf_flush_count", bus.flush_count, 32'd1);
        check("perf_loaduse_count", 32'(bus.loaduse_count), 32'd1);
`endif

        // rt path, gated by id_uses_rt; non-load in EX ignored.
        drive(5'd0, 5'd9, 1'b0, 1'b0, 3'b001, 5'd9, 3'b000, 1'b0, 1'b0);
        check("lu_rt_unused", 32'(obs()), 32'(V_RUN));
        drive(5'd0, 5'd9, 1'b0, 1'b1, 3'b001, 5'd9, 3'b000, 1'b0, 1'b0);
        check("lu_rt_used", 32'(obs()), 32'(V_LU));
        drive(5'd9, 5'd9, 1'b1, 1'b1, 3'b100, 5'd9, 3'b000, 1'b0, 1'b0);
        check("no_lu_non_load", 32'(obs()), 32'(V_RUN));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b1);
        check("ready_no_req", 32'(obs()), 32'(V_RUN));
        tick();
        check("ready_no_req_state", 32'(obs()), 32'(V_RUN));

        // Memory stall beats branch; branch is applied on release.
        drive(5'd5, 5'd0, 1'b1, 1'b0, 3'b101, 5'd5, 3'b010, 1'b1, 1'b0);
        check("stall_over_branch", 32'(obs()), 32'(V_FRZ_RUN));
        tick();
        check("stall_branch_held", 32'(obs()), 32'(V_FRZ_MW));
        drive(5'd5, 5'd0, 1'b1, 1'b0, 3'b101, 5'd5, 3'b010, 1'b1, 1'b1);
        check("release_branch", 32'(obs()), 32'(V_BR_MW));
        tick();
        idle();
        check("release_branch_run", 32'(obs()), 32'(V_RUN));

        // Timeout: 4 consecutive misses with MAX_WAIT=4.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd0, 3'b001, 1'b0, 1'b0);
        check("to_miss1", 32'(obs()), 32'(V_FRZ_RUN));
        tick();
        check("to_miss2", 32'(obs()), 32'(V_FRZ_MW));
        tick();
        check("to_miss3", 32'(obs()), 32'(V_FRZ_MW));
        tick();
        check("to_miss4", 32'(obs()), 32'(V_FRZ_MW));
        tick();
        check("halt_entered", 32'(obs()), 32'(V_HALT));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd0, 3'b001, 1'b0, 1'b1);
        tick();
        check("halt_sticky", 32'(obs()), 32'(V_HALT));
        rst = 1'b1;
        #1;
        check("halt_async_reset", 32'(obs()), 32'(V_RESET));
        tick();
        rst = 1'b0;
        idle();
        check("after_halt_reset", 32'(obs()), 32'(V_RUN));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
